// File: rtl/pipe_ifid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ifid
//  Purpose  : IF/ID pipeline register with a one-entry skid buffer. The fetch
//             side sees a registered ready. Decode-side stalls are absorbed
//             by the skid entry, so no word is lost or duplicated. Flush
//             discards everything that is held or arriving in that cycle.
//             Two saturating counters track stalled cycles and flush cycles.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             if_inst/if_npc    - fetched word and its PC+4
//             if_valid/if_ready - fetch handshake (if_ready registered)
//             id_stall          - decode cannot consume the presented word
//             flush             - discard all buffered and incoming words
//             id_inst/id_npc    - word presented to decode and its PC+4
//             id_valid          - id_inst/id_npc hold a real instruction
//             stall_cnt         - cycles with id_valid & id_stall (saturating)
//             flush_cnt         - cycles with flush asserted (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ifid #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_npc,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             id_stall,
  input  logic             flush,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_npc,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold_inst;
  logic [31:0] hold_npc;
  logic        accept;
  logic        consume;
  logic        load_prim_if;   // primary <= incoming fetch word
  logic        load_prim_hold; // primary <= skid word
  logic        load_hold;      // skid    <= incoming fetch word

  assign accept  = if_valid & if_ready;
  assign consume = id_valid & ~id_stall;

  always_comb begin
    state_nxt      = state;
    load_prim_if   = 1'b0;
    load_prim_hold = 1'b0;
    load_hold      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = FULL;
          load_prim_if = 1'b1;
        end
      end
      FULL: begin
        if (accept && consume) begin
          load_prim_if = 1'b1;
        end else if (accept) begin
          state_nxt = SKID;
          load_hold = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        // if_ready is low here, so no accept can happen.
        if (consume) begin
          state_nxt      = FULL;
          load_prim_hold = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over every transition and drops the incoming word.
    if (flush) begin
      state_nxt      = EMPTY;
      load_prim_if   = 1'b0;
      load_prim_hold = 1'b0;
      load_hold      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      id_inst   <= NOP;
      id_npc    <= 32'h0;
      id_valid  <= 1'b0;
      if_ready  <= 1'b1;
      hold_inst <= 32'h0;
      hold_npc  <= 32'h0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Flags follow the next state so they stay purely register-driven.
      if_ready <= (state_nxt != SKID);
      id_valid <= (state_nxt != EMPTY);

      if (state_nxt == EMPTY) begin
        id_inst <= NOP;  // id_npc deliberately keeps its last value
      end else if (load_prim_if) begin
        id_inst <= if_inst;
        id_npc  <= if_npc;
      end else if (load_prim_hold) begin
        id_inst <= hold_inst;
        id_npc  <= hold_npc;
      end

      if (flush) begin
        hold_inst <= 32'h0;
        hold_npc  <= 32'h0;
      end else if (load_hold) begin
        hold_inst <= if_inst;
        hold_npc  <= if_npc;
      end

      if (id_valid && id_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ifid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ifid
//  Purpose  : Self-checking bench for pipe_ifid. Accepted words are queued
//             as expected decode traffic; a monitor pops and compares on every
//             consume. Directed checks cover reset, stalls, flush and
//             counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ifid;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      if_inst;
  logic [31:0]      if_npc;
  logic             if_valid;
  logic             if_ready;
  logic             id_stall;
  logic             flush;
  logic [31:0]      id_inst;
  logic [31:0]      id_npc;
  logic             id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  pipe_ifid #(.NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_inst(if_inst), .if_npc(if_npc), .if_valid(if_valid), .if_ready(if_ready),
    .id_stall(id_stall), .flush(flush),
    .id_inst(id_inst), .id_npc(id_npc), .id_valid(id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every consume must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (!rst && id_valid && !id_stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_word: got %h/%h expected no word", id_inst, id_npc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({id_inst, id_npc} !== e) begin
          n_err++;
          $display("FAIL sb_word: got %h/%h expected %h/%h",
                   id_inst, id_npc, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Acceptance recorder: runs after the monitor within the same cycle.
  always @(negedge clk) begin
    #1;
    if (rst || flush) exp_q.delete();
    else if (if_valid && if_ready) exp_q.push_back({if_inst, if_npc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] inst, input logic [31:0] npc,
                     input logic v, input logic st, input logic fl);
    if_inst = inst; if_npc = npc; if_valid = v; id_stall = st; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_inst = '0; if_npc = '0; if_valid = 1'b0; id_stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_ready", {31'b0, if_ready}, 32'd1);
    chk("rst_inst", id_inst, NOP);
    chk("rst_npc", id_npc, 32'h0);
    chk("rst_stallcnt", {28'b0, stall_cnt}, 32'd0);
    chk("rst_flushcnt", {28'b0, flush_cnt}, 32'd0);

    // First word after reset
    cyc(32'h2008_0005, 32'h4, 1, 0, 0);
    chk("first_inst", id_inst, 32'h2008_0005);
    chk("first_npc", id_npc, 32'h4);
    chk("first_valid", {31'b0, id_valid}, 32'd1);
    chk("first_ready", {31'b0, if_ready}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("drain_inst", id_inst, NOP);

    // Stall with skid: A, B, C
    do_reset();
    cyc(32'hAAAA_0001, 32'h100, 1, 0, 0);
    cyc(32'hBBBB_0002, 32'h104, 1, 1, 0);
    chk("skid_ready", {31'b0, if_ready}, 32'd0);
    chk("skid_inst", id_inst, 32'hAAAA_0001);
    cyc(32'hCCCC_0003, 32'h108, 1, 1, 0);
    cyc(32'hCCCC_0003, 32'h108, 1, 1, 0);
    chk("skid_hold_ready", {31'b0, if_ready}, 32'd0);
    cyc(32'hCCCC_0003, 32'h108, 1, 0, 0);
    chk("unskid_inst", id_inst, 32'hBBBB_0002);
    chk("unskid_npc", id_npc, 32'h104);
    chk("unskid_ready", {31'b0, if_ready}, 32'd1);
    cyc(32'hCCCC_0003, 32'h108, 1, 0, 0);
    chk("c_inst", id_inst, 32'hCCCC_0003);
    cyc(0, 0, 0, 0, 0);
    chk("abc_empty_valid", {31'b0, id_valid}, 32'd0);
    chk("abc_empty_inst", id_inst, NOP);
    chk("abc_empty_npc", id_npc, 32'h108);
    chk("abc_stallcnt", {28'b0, stall_cnt}, 32'd3);

    // Flush while in SKID with an incoming word
    do_reset();
    cyc(32'hDDDD_0004, 32'h200, 1, 0, 0);
    cyc(32'hEEEE_0005, 32'h204, 1, 1, 0);
    cyc(32'hFFFF_0006, 32'h208, 1, 1, 1);
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_inst", id_inst, NOP);
    chk("flush_ready", {31'b0, if_ready}, 32'd1);
    chk("flush_cnt", {28'b0, flush_cnt}, 32'd1);
    chk("flush_stallcnt", {28'b0, stall_cnt}, 32'd2);
    cyc(32'h1234_0007, 32'h300, 1, 0, 0);
    chk("post_flush_inst", id_inst, 32'h1234_0007);
    cyc(0, 0, 0, 0, 0);

    // Steady stream, no stalls
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(32'h5000_0000 + i, 32'h400 + 4 * i, 1, 0, 0);
      chk("stream_inst", id_inst, 32'h5000_0000 + i);
      chk("stream_ready", {31'b0, if_ready}, 32'd1);
    end
    cyc(0, 0, 0, 0, 0);

    // Reset together with flush while in SKID
    do_reset();
    cyc(32'h6666_0000, 32'h500, 1, 0, 1);
    chk("drop_valid", {31'b0, id_valid}, 32'd0);
    cyc(32'h6666_0001, 32'h504, 1, 0, 0);
    cyc(32'h6666_0002, 32'h508, 1, 1, 0);
    chk("pre_rst_ready", {31'b0, if_ready}, 32'd0);
    rst = 1'b1; flush = 1'b1; if_valid = 1'b1; id_stall = 1'b1;
    if_inst = 32'h6666_0003; if_npc = 32'h50C;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    chk("rf_valid", {31'b0, id_valid}, 32'd0);
    chk("rf_ready", {31'b0, if_ready}, 32'd1);
    chk("rf_inst", id_inst, NOP);
    chk("rf_npc", id_npc, 32'h0);
    chk("rf_stallcnt", {28'b0, stall_cnt}, 32'd0);
    chk("rf_flushcnt", {28'b0, flush_cnt}, 32'd0);
    cyc(32'h7777_0001, 32'h600, 1, 0, 0);
    chk("after_rst_inst", id_inst, 32'h7777_0001);
    cyc(0, 0, 0, 0, 0);

    // Stall counter saturation
    do_reset();
    cyc(32'h8888_0001, 32'h700, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 1, 0);
    chk("sat_cnt10", {28'b0, stall_cnt}, 32'd10);
    repeat (10) cyc(0, 0, 0, 1, 0);
    chk("sat_cnt20", {28'b0, stall_cnt}, 32'd15);
    chk("sat_inst", id_inst, 32'h8888_0001);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ifid.md
PIPE_IFID -- requirements
Module: pipe_ifid

Interface
REQ-001 Parameter: NOP, default 32'h00000000, instruction word presented on id_inst whenever id_valid is 0.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 if_inst  input  32  Fetched instruction word from the fetch stage.
REQ-006 if_npc  input  32  PC+4 of the fetched instruction.
REQ-007 if_valid  input  1  if_inst/if_npc hold a real fetched instruction this cycle.
REQ-008 if_ready  output  1  Block accepts a word this cycle; the fetch stage holds its PC when low.
REQ-009 id_stall  input  1  Decode stage cannot consume the presented word this cycle (hazard).
REQ-010 flush  input  1  Taken branch/jump resolved; discard every buffered and incoming word.
REQ-011 id_inst  output  32  Instruction presented to decode.
REQ-012 id_npc  output  32  PC+4 paired with id_inst.
REQ-013 id_valid  output  1  id_inst/id_npc are a real instruction.
REQ-014 stall_cnt  output  CNT_W  Cycles with id_valid=1 and id_stall=1, saturating.
REQ-015 flush_cnt  output  CNT_W  Cycles with flush=1, saturating.

Function
REQ-016 accept = if_valid & if_ready; consume = id_valid & ~id_stall.
REQ-017 Storage: a primary register (id_inst/id_npc) and one skid register (hold_inst/hold_npc); no other data storage.
REQ-018 States: EMPTY (primary invalid), FULL (primary valid, skid empty), SKID (both valid); encoding is free.
REQ-019 if_ready is a registered output, 1 in EMPTY and FULL, 0 in SKID; no combinational path from id_stall or if_valid to if_ready.
REQ-020 id_valid is 1 in FULL and SKID, 0 in EMPTY; every output is register-driven.
REQ-021 EMPTY: accept -> FULL, primary <= if word; otherwise stay.
REQ-022 FULL: accept & consume -> FULL, primary <= if word; accept & ~consume -> SKID, skid <= if word; ~accept & consume -> EMPTY; neither -> stay, primary unchanged.
REQ-023 SKID: consume -> FULL, primary <= skid word; otherwise stay, both registers unchanged; no accept is possible.
REQ-024 Ordering: words reach decode in exactly the order accepted; no word is duplicated or lost unless flushed.
REQ-025 Latency: an accepted word appears on id_* on the cycle after acceptance when the block was EMPTY, or FULL with consume.
REQ-026 flush (rst=0) has priority over all transitions: next state EMPTY, the incoming word is dropped even if accept=1, the skid is discarded, and if_ready becomes 1 next cycle.
REQ-027 Whenever the next state is EMPTY, id_inst <= NOP; id_npc keeps its last value.
REQ-028 stall_cnt increments by 1 each cycle with id_valid & id_stall and holds at all-ones; flush_cnt likewise for flush; both are unaffected by flush itself except flush_cnt.

Reset
REQ-029 rst=1 at a clock edge forces state EMPTY, id_inst=NOP, id_npc=0, id_valid=0, if_ready=1, skid cleared, stall_cnt=0, flush_cnt=0, and overrides flush and accept in the same cycle.
REQ-030 Reset asserted mid-operation (FULL or SKID) discards all held words; the first word accepted after reset deasserts is the first presented to decode.

Verification
REQ-031 After rst, present if_inst=32'h20080005, if_npc=32'h4, if_valid=1, id_stall=0 -> next cycle id_inst=32'h20080005, id_npc=32'h4, id_valid=1, if_ready=1.
REQ-032 Stream words A,B,C; hold id_stall=1 from the cycle after A appears -> B captured in skid, if_ready=0 next cycle, C held upstream; release id_stall -> decode sees A,B,C in order, stall_cnt equals number of stalled cycles.
REQ-033 In SKID state assert flush with if_valid=1 -> next cycle id_valid=0, id_inst=NOP, if_ready=1, flush_cnt=1; the flushed words never appear on id_inst.
REQ-034 Steady stream with id_stall=0 for 8 cycles -> one word per cycle, if_ready constantly 1, never enters SKID.
REQ-035 In SKID assert rst together with flush -> next cycle all outputs at reset values, flush_cnt=0.
REQ-036 With CNT_W=4 hold id_valid=1, id_stall=1 for 20 cycles -> stall_cnt saturates at 4'hF and stays.
